// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and helpers for the system-bus arbiters.
//   arb_state_t          : arbiter FSM state (IDLE, OWNED)
//   MAX_MASTERS          : widest master vector the onehot helper supports
//   LAST_OWNER_RST_BACK  : reset value of last_owner is NUM_MASTERS minus this,
//                          so the first search after reset starts at master 0
//   onehot()             : index -> one-hot vector (MAX_MASTERS wide)
// ---------------------------------------------------------------------------
package bus_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   localparam int unsigned MAX_MASTERS         = 32;
   localparam int unsigned LAST_OWNER_RST_BACK = 1;

   function automatic logic [MAX_MASTERS-1:0] onehot(input int unsigned idx);
      return {{(MAX_MASTERS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search. Finds the first set bit of 'eligible'
// starting at (last_owner+1) mod NUM_MASTERS and wrapping upward.
//   eligible   : input  [NUM_MASTERS-1:0] candidate mask
//   last_owner : input  [ID_W-1:0]        most recent winner
//   found      : output                   any eligible bit set
//   win_id     : output [ID_W-1:0]        winning index (0 when !found)
//   win_onehot : output [NUM_MASTERS-1:0] winning index as one-hot
// ---------------------------------------------------------------------------
module rr_picker #(
   parameter  int NUM_MASTERS = 2,
   localparam int ID_W        = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] eligible,
   input  logic [ID_W-1:0]        last_owner,
   output logic                   found,
   output logic [ID_W-1:0]        win_id,
   output logic [NUM_MASTERS-1:0] win_onehot
);

   logic [ID_W-1:0] cand;

   always_comb begin
      // NOTE: every combinational output is given a default before any
      // conditional write, so no path can leave it unassigned (no latch).
      found      = 1'b0;
      win_id     = '0;
      win_onehot = '0;
      cand       = '0;
      // Walk from the farthest offset to the nearest; the nearest eligible
      // index after last_owner is written last and therefore wins.
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         cand = ID_W'((32'(last_owner) + 32'(k)) % 32'(NUM_MASTERS));
         if (eligible[cand]) begin
            found            = 1'b1;
            win_id           = cand;
            win_onehot       = '0;
            win_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the shared serial system bus with one tracked
// split transaction. A granted master holds the bus until it drops req.
// Optional feature macro: BUS_ARB_SPLIT_EN (split parking / resume). When
// undefined, split_en/split_resume are ignored and split outputs tie to 0.
//   in_clk        : input   bus clock (rising edge)
//   reset_n       : input   asynchronous active-low reset
//   req           : input   [NUM_MASTERS-1:0] per-master request
//   split_en      : input   split indication from addressed slave
//   split_resume  : input   pulse, split slave ready to complete
//   gnt           : output  [NUM_MASTERS-1:0] one-hot registered grant
//   gnt_id        : output  [ID_W-1:0] granted index (valid while bus_busy)
//   bus_busy      : output  any grant active
//   split_pending : output  a master is parked on a split
//   split_id      : output  [ID_W-1:0] parked index (valid while pending)
// ---------------------------------------------------------------------------
module bus_arbiter #(
   parameter  int NUM_MASTERS = 2,
   localparam int ID_W        = $clog2(NUM_MASTERS)
) (
   input  logic                   in_clk,
   input  logic                   reset_n,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   split_en,
   input  logic                   split_resume,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic [ID_W-1:0]        gnt_id,
   output logic                   bus_busy,
   output logic                   split_pending,
   output logic [ID_W-1:0]        split_id
);

   import bus_arb_pkg::*;

   localparam logic [ID_W-1:0] LAST_OWNER_RST =
      ID_W'(32'(NUM_MASTERS) - LAST_OWNER_RST_BACK);

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]        last_owner_q, last_owner_d;
   logic [NUM_MASTERS-1:0] eligible;
   logic                   pick_found;
   logic [ID_W-1:0]        pick_id;
   logic [NUM_MASTERS-1:0] pick_onehot;

`ifdef BUS_ARB_SPLIT_EN
   logic                   split_pending_q, split_pending_d;
   logic [ID_W-1:0]        split_id_q, split_id_d;
   logic                   resumed_q, resumed_d;

   // The parked master only regains the bus through the resume path.
   assign eligible = req & ~(split_pending_q ? NUM_MASTERS'(onehot(32'(split_id_q)))
                                             : {NUM_MASTERS{1'b0}});
`else
   logic                   unused_split_inputs;

   assign unused_split_inputs = split_en ^ split_resume;
   assign eligible            = req;
`endif

   rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .eligible   (eligible),
      .last_owner (last_owner_q),
      .found      (pick_found),
      .win_id     (pick_id),
      .win_onehot (pick_onehot)
   );

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      gnt_id_d     = gnt_id_q;
      last_owner_d = last_owner_q;
`ifdef BUS_ARB_SPLIT_EN
      split_pending_d = split_pending_q;
      split_id_d      = split_id_q;
      // A resume arriving with the split_en that creates the split is
      // dropped, because split_pending_q is not yet set on that edge.
      resumed_d       = resumed_q | (split_resume & split_pending_q);
`endif
      case (state_q)
         IDLE: begin
`ifdef BUS_ARB_SPLIT_EN
            if (split_pending_q && resumed_q && req[split_id_q]) begin
               gnt_d           = NUM_MASTERS'(onehot(32'(split_id_q)));
               gnt_id_d        = split_id_q;
               last_owner_d    = split_id_q;
               state_d         = OWNED;
               split_pending_d = 1'b0;
               resumed_d       = 1'b0;
            end else
`endif
            if (pick_found) begin
               gnt_d        = pick_onehot;
               gnt_id_d     = pick_id;
               last_owner_d = pick_id;
               state_d      = OWNED;
            end
         end
         OWNED: begin
`ifdef BUS_ARB_SPLIT_EN
            // A split takes precedence over a simultaneous req drop; a
            // second split while one is pending is ignored.
            if (split_en && !split_pending_q) begin
               split_pending_d = 1'b1;
               split_id_d      = gnt_id_q;
               gnt_d           = '0;
               state_d         = IDLE;
            end else
`endif
            if (!req[gnt_id_q]) begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample the same pre-edge values.
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         gnt_id_q     <= '0;
         last_owner_q <= LAST_OWNER_RST;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         gnt_id_q     <= gnt_id_d;
         last_owner_q <= last_owner_d;
      end
   end

`ifdef BUS_ARB_SPLIT_EN
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         split_pending_q <= 1'b0;
         split_id_q      <= '0;
         resumed_q       <= 1'b0;
      end else begin
         split_pending_q <= split_pending_d;
         split_id_q      <= split_id_d;
         resumed_q       <= resumed_d;
      end
   end

   assign split_pending = split_pending_q;
   assign split_id      = split_id_q;
`else
   assign split_pending = 1'b0;
   assign split_id      = '0;
`endif

   assign gnt      = gnt_q;
   assign gnt_id   = gnt_id_q;
   assign bus_busy = |gnt_q;

endmodule
